// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter between the core and a UART loader; UART wins, the core stalls.
// Define DMEM_ARB_FAIRNESS_EN to add a forced core slot after BURST_MAX stalled UART cycles.
module dmem_arbiter #(
  parameter int unsigned WORD_LEN  = 32,
  parameter int unsigned BURST_MAX = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                core_req,
  input  logic                wen_core,
  input  logic [WORD_LEN-1:0] addr_d_core,
  input  logic [WORD_LEN-1:0] wdata_core,
  input  logic                intr,
  input  logic [WORD_LEN-1:0] addr_d_uart,
  input  logic [WORD_LEN-1:0] wdata_uart,
  output logic                wen_mem,
  output logic [WORD_LEN-1:0] addr_d_mem,
  output logic [WORD_LEN-1:0] wdata_mem,
  output logic                gnt_uart,
  output logic                stall_core
);

  if (BURST_MAX < 2 || BURST_MAX > 15) begin : g_burst_range
    $error("dmem_arbiter: BURST_MAX must be within 2..15");
  end

`ifdef DMEM_ARB_FAIRNESS_EN
  typedef enum logic [1:0] {
    CORE = 2'd0,
    UART = 2'd1,
    SLOT = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    CORE = 2'd0,
    UART = 2'd1
  } state_t;
`endif

  state_t state;

`ifdef DMEM_ARB_FAIRNESS_EN
  localparam logic [3:0] BURST_LAST = 4'(BURST_MAX - 1);

  logic [3:0] burst_cnt;

  // intr falling is tested first so it always beats a pending slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= CORE;
      burst_cnt <= '0;
    end else begin
      case (state)
        CORE: begin
          burst_cnt <= '0;
          if (intr) state <= UART;
        end
        UART: begin
          if (!intr) begin
            state     <= CORE;
            burst_cnt <= '0;
          end else if (core_req && burst_cnt == BURST_LAST) begin
            state     <= SLOT;
            burst_cnt <= '0;
          end else if (core_req) begin
            burst_cnt <= burst_cnt + 4'd1;
          end
        end
        SLOT: begin
          burst_cnt <= '0;
          state     <= intr ? UART : CORE;
        end
        default: begin
          state     <= CORE;
          burst_cnt <= '0;
        end
      endcase
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CORE;
    end else begin
      case (state)
        CORE:    if (intr) state <= UART;
        UART:    if (!intr) state <= CORE;
        default: state <= CORE;
      endcase
    end
  end
`endif

  // Reset gating keeps the write enable and grant low for the whole reset window.
  always_comb begin
    wen_mem    = wen_core & core_req;
    addr_d_mem = addr_d_core;
    wdata_mem  = wdata_core;
    gnt_uart   = 1'b0;
    stall_core = 1'b0;
    if (state == UART) begin
      wen_mem    = 1'b1;
      addr_d_mem = addr_d_uart;
      wdata_mem  = wdata_uart;
      gnt_uart   = 1'b1;
      stall_core = core_req;
    end
    if (!rst_n) begin
      wen_mem    = 1'b0;
      gnt_uart   = 1'b0;
      stall_core = 1'b0;
    end
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter BURST_MAX, default 4: maximum consecutive UART-owned cycles before a forced core slot (fairness only, range 2..15).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 core_req  input  1  core requests the data-memory port this cycle.
REQ-005 wen_core  input  1  core write enable.
REQ-006 addr_d_core  input  WORD_LEN  core address.
REQ-007 wdata_core  input  WORD_LEN  core write data.
REQ-008 intr  input  1  UART requests the port; held high until its transfer completes.
REQ-009 addr_d_uart  input  WORD_LEN  UART address.
REQ-010 wdata_uart  input  WORD_LEN  UART write data; UART accesses are always writes.
REQ-011 wen_mem  output  1  memory write enable.
REQ-012 addr_d_mem  output  WORD_LEN  memory address.
REQ-013 wdata_mem  output  WORD_LEN  memory write data.
REQ-014 gnt_uart  output  1  UART owns the port this cycle; UART advances its transfer only when this is high.
REQ-015 stall_core  output  1  core request is not served this cycle; core holds its request.

Function
REQ-016 The FSM shall have states CORE (reset/default), UART and SLOT; the state and a 4-bit burst counter shall be the only registers.
REQ-017 In CORE and SLOT the outputs shall equal the core inputs (wen_mem = wen_core & core_req), with gnt_uart=0 and stall_core=0.
REQ-018 In UART the outputs shall be wen_mem=1, addr_d_mem=addr_d_uart, wdata_mem=wdata_uart, gnt_uart=1, stall_core=core_req.
REQ-019 Output muxing shall be combinational from the registered state: zero-cycle latency for the current owner, one-cycle latency on ownership change.
REQ-020 CORE->UART when intr=1 at the edge; if intr and core_req rise in the same cycle, the core is served that cycle and the UART from the next.
REQ-021 UART->CORE when intr=0 at the edge; the counter shall clear on every UART exit.
REQ-022 In UART the counter shall increment each cycle that core_req=1 and hold when core_req=0.
REQ-023 UART->SLOT when the counter equals BURST_MAX-1, core_req=1 and intr=1 (fairness enabled only).
REQ-024 SLOT shall last exactly one cycle, then go to UART if intr=1, else CORE; the counter clears on SLOT entry.
REQ-025 intr deassertion shall take priority over SLOT entry.
REQ-026 No access shall be lost: every cycle has exactly one owner, and a stalled core request is served no later than the first non-UART cycle.

Reset
REQ-027 While rst_n=0: state=CORE, counter=0, gnt_uart=0, stall_core=0, wen_mem=0 (forced), addr_d_mem/wdata_mem follow core inputs.
REQ-028 Reset asserted during UART ownership shall drop gnt_uart asynchronously; no partial-cycle write enable shall be produced.

Configuration
REQ-029 Macro DMEM_ARB_FAIRNESS_EN defined: the SLOT state and burst counter exist, with REQ-022..REQ-024 active.
REQ-030 Macro undefined: strict UART priority; SLOT and counter are not built; the core waits until intr falls.

Verification
REQ-031 Idle core traffic: core_req=1, wen_core=1, addr 0x1000, data 0x41 -> wen_mem=1, addr_d_mem=0x1000, wdata_mem=0x41 the same cycle; stall_core=0.
REQ-032 UART burst: intr high 3 cycles, core idle -> gnt_uart high from the next cycle for 3 cycles, wen_mem=1 with UART address/data; returns to CORE one cycle after intr falls.
REQ-033 Simultaneous request: intr and core_req rise together -> core write in cycle N, gnt_uart=1 and stall_core=1 from N+1.
REQ-034 Fairness (macro defined, BURST_MAX=4): intr and core_req held high -> pattern of 4 UART cycles, 1 core cycle, repeating; macro undefined -> core stalled until intr drops.
REQ-035 Reset mid-UART: rst_n low during the 2nd UART cycle -> gnt_uart=0 and wen_mem=0 immediately; after release state is CORE with counter 0.
